// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback sequencer: FSM state encoding,
// writeback source codes as decoded by the memToReg mux, and datapath widths.
package wb_pkg;

  localparam int SRC_W = 4;
  localparam int REG_W = 5;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_WRITE
  } wb_state_e;

  localparam logic [SRC_W-1:0] SRC_ALU      = 4'd0;
  localparam logic [SRC_W-1:0] SRC_LOAD     = 4'd1;
  localparam logic [SRC_W-1:0] SRC_HI       = 4'd2;
  localparam logic [SRC_W-1:0] SRC_LO       = 4'd3;
  localparam logic [SRC_W-1:0] SRC_LUI      = 4'd4;
  localparam logic [SRC_W-1:0] SRC_PC8      = 4'd5;
  localparam logic [SRC_W-1:0] SRC_SLT      = 4'd6;
  localparam logic [SRC_W-1:0] SRC_SHIFT    = 4'd7;
  localparam logic [SRC_W-1:0] SRC_CONST227 = 4'd8;
  localparam logic [SRC_W-1:0] SRC_A        = 4'd9;
  localparam logic [SRC_W-1:0] SRC_B        = 4'd10;

  function automatic logic src_legal(input logic [SRC_W-1:0] src);
    return src <= SRC_B;
  endfunction

endpackage

// File: rtl/wb_src_ready.sv
// Combinational readiness decode for the captured writeback source:
// loads wait on LoadSize, HI/LO reads wait for the mult/div unit.
module wb_src_ready
  import wb_pkg::*;
(
  input  logic [SRC_W-1:0] src_i,
  input  logic             load_done_i,
  input  logic             hilo_busy_i,
  output logic             ready_o
);

  always_comb begin
    ready_o = 1'b1;
    unique case (src_i)
      SRC_LOAD:       ready_o = load_done_i;
      SRC_HI, SRC_LO: ready_o = !hilo_busy_i;
      default:        ready_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts one request in IDLE, waits for its source, then
// pulses the register-file write. Optional WAIT timeout enabled by WB_TIMEOUT_EN.
module wb_sequencer
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SRC_W-1:0] req_src,
  input  logic [REG_W-1:0] req_rd,
  input  logic             load_done,
  input  logic             hilo_busy,
  input  logic             err_clr,
  output logic [SRC_W-1:0] mem_to_reg,
  output logic             reg_write,
  output logic [REG_W-1:0] wr_reg,
  output logic             busy,
  output logic             err_illegal,
  output logic             err_timeout
);

  wb_state_e        state_q, state_d;
  logic [SRC_W-1:0] src_q, src_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             err_illegal_q, err_illegal_d;
  logic             err_timeout_q, err_timeout_d;
  logic             src_ready;
  logic             timeout_hit;

  wb_src_ready u_src_ready (
    .src_i       (src_q),
    .load_done_i (load_done),
    .hilo_busy_i (hilo_busy),
    .ready_o     (src_ready)
  );

`ifdef WB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             handshake;

  assign handshake = req_valid && req_ready;
  assign cnt_inc   = cnt_q + 1'b1;
  // A source that turns ready on the final count still gets its write.
  assign timeout_hit = (state_q == ST_WAIT) && !src_ready &&
                       (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = cnt_q;
    if (handshake) begin
      cnt_d = '0;
    end else if (state_q == ST_WAIT) begin
      cnt_d = cnt_inc;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    rd_d          = rd_q;
    err_illegal_d = err_illegal_q && !err_clr;
    err_timeout_d = err_timeout_q && !err_clr;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          src_d = req_src;
          rd_d  = req_rd;
          if (src_legal(req_src)) begin
            state_d = ST_WAIT;
          end else begin
            err_illegal_d = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (src_ready) begin
          state_d = ST_WRITE;
        end else if (timeout_hit) begin
          state_d       = ST_IDLE;
          err_timeout_d = 1'b1;
        end
      end
      ST_WRITE: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      src_q         <= '0;
      rd_q          <= '0;
      err_illegal_q <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      rd_q          <= rd_d;
      err_illegal_q <= err_illegal_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  // Writes to r0 still walk through WRITE so latency stays uniform.
  assign req_ready   = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign reg_write   = (state_q == ST_WRITE) && (rd_q != '0);
  assign mem_to_reg  = src_q;
  assign wr_reg      = rd_q;
  assign err_illegal = err_illegal_q;
  assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_wb_sequencer;

  localparam int TIMEOUT = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic       reqValid;
  logic       reqReady;
  logic [3:0] reqSrc;
  logic [4:0] reqRd;
  logic       loadDone;
  logic       hiloBusy;
  logic       errClr;
  logic [3:0] memToReg;
  logic       regWrite;
  logic [4:0] wrReg;
  logic       busy;
  logic       errIllegal;
  logic       errTimeout;

  int checks = 0;
  int errors = 0;

  // Model: a request is either waiting on its source, or due to write this cycle.
  bit         mInFlight;
  bit         mWriteDue;
  logic [3:0] mSrc;
  logic [4:0] mRd;
  bit         mIllegal;
  bit         mTimeout;
  int         mWaits;

  wb_sequencer #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (reqValid),
    .req_ready   (reqReady),
    .req_src     (reqSrc),
    .req_rd      (reqRd),
    .load_done   (loadDone),
    .hilo_busy   (hiloBusy),
    .err_clr     (errClr),
    .mem_to_reg  (memToReg),
    .reg_write   (regWrite),
    .wr_reg      (wrReg),
    .busy        (busy),
    .err_illegal (errIllegal),
    .err_timeout (errTimeout)
  );

  always #5 clk = ~clk;

  function automatic bit modelSrcReady(input logic [3:0] s, input logic ld, input logic hb);
    if (s == 4'd1) return ld;
    if (s == 4'd2 || s == 4'd3) return !hb;
    return 1'b1;
  endfunction

  task automatic modelReset();
    mInFlight = 0; mWriteDue = 0; mSrc = '0; mRd = '0;
    mIllegal = 0; mTimeout = 0; mWaits = 0;
  endtask

  task automatic modelEdge();
    bit accept;
    accept   = reqValid && !(mInFlight || mWriteDue);
    mIllegal = mIllegal && !errClr;
    mTimeout = mTimeout && !errClr;
    if (mWriteDue) begin
      mWriteDue = 0;
    end else if (mInFlight) begin
      if (modelSrcReady(mSrc, loadDone, hiloBusy)) begin
        mInFlight = 0;
        mWriteDue = 1;
      end
`ifdef WB_TIMEOUT_EN
      else begin
        mWaits++;
        if (mWaits == TIMEOUT) begin
          mInFlight = 0;
          mTimeout  = 1;
        end
      end
`endif
    end else if (accept) begin
      mSrc = reqSrc;
      mRd  = reqRd;
      if (reqSrc > 4'd10) begin
        mIllegal = 1;
      end else begin
        mInFlight = 1;
        mWaits    = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    bit mBusy;
    mBusy = mInFlight || mWriteDue;
    checkOutput({tag, "_ready"},   8'(reqReady),   8'(!mBusy));
    checkOutput({tag, "_busy"},    8'(busy),       8'(mBusy));
    checkOutput({tag, "_regwr"},   8'(regWrite),   8'(mWriteDue && (mRd != 0)));
    checkOutput({tag, "_m2r"},     8'(memToReg),   8'(mSrc));
    checkOutput({tag, "_wrreg"},   8'(wrReg),      8'(mRd));
    checkOutput({tag, "_illegal"}, 8'(errIllegal), 8'(mIllegal));
    checkOutput({tag, "_timeout"}, 8'(errTimeout), 8'(mTimeout));
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] s, input logic [4:0] rd,
                               input logic ld, input logic hb, input logic clr);
    reqValid = v; reqSrc = s; reqRd = rd; loadDone = ld; hiloBusy = hb; errClr = clr;
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll(tag);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0);
    modelReset();
    @(negedge clk);
    checkAll("reset");
    reset = 1'b0;

    // Plain ALU write: WAIT then a single WRITE cycle.
    applyStimulus(1, 4'd0, 5'd5, 0, 0, 0);
    stepCycle("alu_hs");
    checkOutput("alu_hs_regwr_const", 8'(regWrite), 8'd0);
    applyStimulus(0, 4'd3, 5'd9, 0, 0, 0);
    stepCycle("alu_wr");
    checkOutput("alu_wr_regwr_const", 8'(regWrite), 8'd1);
    checkOutput("alu_wr_wrreg_const", 8'(wrReg), 8'd5);
    stepCycle("alu_idle");
    checkOutput("alu_idle_ready_const", 8'(reqReady), 8'd1);

    // Load held off by load_done for 4 cycles.
    applyStimulus(1, 4'd1, 5'd7, 0, 0, 0);
    stepCycle("ld_hs");
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      stepCycle("ld_wait");
      checkOutput("ld_wait_busy_const", 8'(busy), 8'd1);
    end
    applyStimulus(0, 4'd0, 5'd0, 1, 0, 0);
    stepCycle("ld_wr");
    checkOutput("ld_wr_regwr_const", 8'(regWrite), 8'd1);
    stepCycle("ld_done");
    checkOutput("ld_done_regwr_const", 8'(regWrite), 8'd0);

    // Illegal source: flag set, no transition; set beats a simultaneous clear.
    applyStimulus(1, 4'd12, 5'd3, 1, 0, 0);
    stepCycle("ill");
    checkOutput("ill_flag_const", 8'(errIllegal), 8'd1);
    checkOutput("ill_ready_const", 8'(reqReady), 8'd1);
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 1);
    stepCycle("ill_clr");
    checkOutput("ill_clr_const", 8'(errIllegal), 8'd0);
    applyStimulus(1, 4'd15, 5'd4, 0, 0, 1);
    stepCycle("ill_setwins");
    checkOutput("ill_setwins_const", 8'(errIllegal), 8'd1);
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 1);
    stepCycle("ill_clr2");

    // Write to r0: two busy cycles, strobe stays low.
    applyStimulus(1, 4'd9, 5'd0, 0, 0, 0);
    stepCycle("r0_hs");
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 0);
    stepCycle("r0_wr");
    checkOutput("r0_wr_busy_const", 8'(busy), 8'd1);
    checkOutput("r0_wr_regwr_const", 8'(regWrite), 8'd0);
    stepCycle("r0_idle");

    // HI source stalled by the mult/div unit for 300 cycles.
    applyStimulus(1, 4'd2, 5'd12, 0, 1, 0);
    stepCycle("hi_hs");
    applyStimulus(0, 4'd0, 5'd0, 0, 1, 0);
    for (int i = 0; i < 300; i++) stepCycle("hi_stall");
`ifdef WB_TIMEOUT_EN
    checkOutput("hi_timeout_const", 8'(errTimeout), 8'd1);
    checkOutput("hi_timeout_busy_const", 8'(busy), 8'd0);
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 1);
    stepCycle("hi_clr");
    checkOutput("hi_clr_const", 8'(errTimeout), 8'd0);
`else
    checkOutput("hi_unbounded_busy_const", 8'(busy), 8'd1);
    checkOutput("hi_unbounded_timeout_const", 8'(errTimeout), 8'd0);
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 0);
    stepCycle("hi_wr");
    checkOutput("hi_wr_regwr_const", 8'(regWrite), 8'd1);
`endif
    stepCycle("hi_idle");

    // Asynchronous reset while waiting on a load: request is dropped.
    applyStimulus(1, 4'd1, 5'd20, 0, 0, 0);
    stepCycle("rst_hs");
    applyStimulus(0, 4'd0, 5'd0, 0, 0, 0);
    stepCycle("rst_wait");
    reset = 1'b1;
    #1;
    modelReset();
    checkAll("rst_async");
    checkOutput("rst_async_busy_const", 8'(busy), 8'd0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(0, 4'd0, 5'd0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      stepCycle("rst_after");
      checkOutput("rst_after_regwr_const", 8'(regWrite), 8'd0);
    end

    // Random traffic against the reference model.
    for (int i = 0; i < 800; i++) begin
      logic [3:0] s;
      logic [4:0] rd;
      s  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(11, 15)) : 4'($urandom_range(0, 10));
      rd = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      applyStimulus(($urandom_range(0, 3) != 0), s, rd,
                    ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) != 0),
                    ($urandom_range(0, 15) == 0));
      stepCycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
